mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage data access controller. Converts a mem-stage
//            load/store into a single SRAM-like bus transaction. It checks
//            alignment, formats store data, extends load data, and stalls the
//            pipeline while a transaction is outstanding.
// Ports    :
//   clk, rst              - clock, synchronous active-high reset
//   exception             - pipeline flush from the CP0/exception unit
//   mem_valid, mem_op     - mem-stage instruction present / access opcode
//   mem_access_mem_addr   - effective address
//   mem_store_data        - rt value for stores
//   mem_exception_type    - nonzero: older exception, suppresses the access
//   data_req/wr/size/addr/wdata - SRAM-like request channel
//   data_addr_ok/data_ok/rdata  - SRAM-like handshake and read data
//   stall_req             - hold upstream stages
//   load_data, load_done  - extended load result / one-cycle valid pulse
//   addr_err_load/store   - AdEL / AdES pulse for a misaligned access
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        mem_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_access_mem_addr,
  input  logic [31:0] mem_store_data,
  input  logic [31:0] mem_exception_type,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall_req,
  output logic [31:0] load_data,
  output logic        load_done,
  output logic        addr_err_load,
  output logic        addr_err_store
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        kill, kill_next;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        wr_q;

  // --------------------------------------------------------------------------
  // Opcode decode helpers (codes outside 1..8 decode as "none")
  // --------------------------------------------------------------------------
  function automatic logic is_load_op(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic [1:0] size_of(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Incoming request qualification
  // --------------------------------------------------------------------------
  logic        in_load, in_store, in_any, in_aligned, in_clean, start;
  logic [1:0]  in_size;
  logic [31:0] in_wdata;

  always_comb begin
    in_load  = is_load_op(mem_op);
    in_store = is_store_op(mem_op);
    in_any   = in_load | in_store;
    in_size  = size_of(mem_op);

    case (in_size)
      SIZE_WORD: in_aligned = (mem_access_mem_addr[1:0] == 2'b00);
      SIZE_HALF: in_aligned = (mem_access_mem_addr[0] == 1'b0);
      default:   in_aligned = 1'b1;
    endcase

    // An older exception or a flush this cycle removes the access entirely,
    // including any alignment error it would otherwise raise.
    in_clean = (state == IDLE) && mem_valid && in_any &&
               (mem_exception_type == 32'd0) && !exception;
    start    = in_clean && in_aligned;

    // Replicate narrow store data across the word so the byte lanes line up
    // regardless of the low address bits.
    case (mem_op)
      OP_SB:   in_wdata = {4{mem_store_data[7:0]}};
      OP_SH:   in_wdata = {2{mem_store_data[15:0]}};
      default: in_wdata = mem_store_data;
    endcase
  end

  assign addr_err_load  = in_clean && !in_aligned && in_load;
  assign addr_err_store = in_clean && !in_aligned && in_store;

  // --------------------------------------------------------------------------
  // Load data extraction from the returned word
  // --------------------------------------------------------------------------
  logic [31:0] rdata_shift;
  logic [15:0] rdata_half;
  logic [31:0] load_ext;

  always_comb begin
    rdata_shift = data_rdata >> {addr_q[1:0], 3'b000};
    rdata_half  = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      OP_LBU:  load_ext = {24'd0, rdata_shift[7:0]};
      OP_LH:   load_ext = {{16{rdata_half[15]}}, rdata_half};
      OP_LHU:  load_ext = {16'd0, rdata_half};
      default: load_ext = data_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  logic capture;
  logic capture_ok;

  always_comb begin
    state_next = state;
    kill_next  = kill;
    capture    = 1'b0;
    load_done  = 1'b0;

    case (state)
      IDLE: begin
        kill_next = 1'b0;
        if (start) state_next = WAIT_ADDR;
      end
      WAIT_ADDR: begin
        if (data_addr_ok) begin
          // Once accepted the bus owes us a response, so a flush only marks
          // the transaction dead; the data_ok must still be consumed.
          kill_next = kill | exception;
          if (data_data_ok) begin
            state_next = DONE;
            capture    = 1'b1;
          end else begin
            state_next = WAIT_DATA;
          end
        end else if (exception) begin
          state_next = IDLE;
        end
      end
      WAIT_DATA: begin
        kill_next = kill | exception;
        if (data_data_ok) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        kill_next  = 1'b0;
        load_done  = is_load_op(op_q) && !kill && !exception;
      end
      default: begin
        state_next = IDLE;
        kill_next  = 1'b0;
      end
    endcase

    capture_ok = capture && is_load_op(op_q) && !kill && !exception;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kill      <= 1'b0;
      op_q      <= 4'd0;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      wdata_q   <= 32'd0;
      wr_q      <= 1'b0;
      load_data <= 32'd0;
    end else begin
      state <= state_next;
      kill  <= kill_next;
      if (start) begin
        op_q    <= mem_op;
        addr_q  <= mem_access_mem_addr;
        size_q  <= in_size;
        wdata_q <= in_wdata;
        wr_q    <= in_store;
      end
      if (capture_ok) load_data <= load_ext;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_req   = (state == WAIT_ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign stall_req  = start || (state == WAIT_ADDR) || (state == WAIT_DATA);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception;
  logic        mem_valid;
  logic [3:0]  mem_op;
  logic [31:0] mem_access_mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] mem_exception_type;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        stall_req;
  logic [31:0] load_data;
  logic        load_done;
  logic        addr_err_load;
  logic        addr_err_store;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .exception           (exception),
    .mem_valid           (mem_valid),
    .mem_op              (mem_op),
    .mem_access_mem_addr (mem_access_mem_addr),
    .mem_store_data      (mem_store_data),
    .mem_exception_type  (mem_exception_type),
    .data_req            (data_req),
    .data_wr             (data_wr),
    .data_size           (data_size),
    .data_addr           (data_addr),
    .data_wdata          (data_wdata),
    .data_addr_ok        (data_addr_ok),
    .data_data_ok        (data_data_ok),
    .data_rdata          (data_rdata),
    .stall_req           (stall_req),
    .load_data           (load_data),
    .load_done           (load_done),
    .addr_err_load       (addr_err_load),
    .addr_err_store      (addr_err_store)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit
  // later, well away from either edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    mem_valid           = 1'b1;
    mem_op              = op;
    mem_access_mem_addr = addr;
    mem_store_data      = sdata;
  endtask

  task automatic drop_issue();
    mem_valid = 1'b0;
    mem_op    = 4'd0;
  endtask

  // Transaction acknowledged in the first WAIT_ADDR cycle: start at T,
  // request at T+1, DONE at T+2.
  task automatic fast(input string tag, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic [31:0] rdata,
                      input logic [1:0] esize, input logic ewr, input logic [31:0] ewdata,
                      input logic eld, input logic [31:0] eload);
    issue(op, addr, sdata);
    settle();
    chk({tag, ".stall_T"}, {31'd0, stall_req}, 32'd1);
    chk({tag, ".req_T"},   {31'd0, data_req},  32'd0);
    step();
    drop_issue();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    settle();
    chk({tag, ".req_T1"},  {31'd0, data_req},  32'd1);
    chk({tag, ".size"},    {30'd0, data_size}, {30'd0, esize});
    chk({tag, ".addr"},    data_addr,          addr);
    chk({tag, ".wr"},      {31'd0, data_wr},   {31'd0, ewr});
    if (ewr) chk({tag, ".wdata"}, data_wdata, ewdata);
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    settle();
    chk({tag, ".done_T2"},  {31'd0, load_done}, {31'd0, eld});
    chk({tag, ".ldata"},    load_data,          eload);
    chk({tag, ".stall_T2"}, {31'd0, stall_req}, 32'd0);
    chk({tag, ".req_T2"},   {31'd0, data_req},  32'd0);
    step();
    settle();
    chk({tag, ".done_T3"},  {31'd0, load_done}, 32'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    exception           = 1'b0;
    mem_valid           = 1'b0;
    mem_op              = 4'd0;
    mem_access_mem_addr = 32'd0;
    mem_store_data      = 32'd0;
    mem_exception_type  = 32'd0;
    data_addr_ok        = 1'b0;
    data_data_ok        = 1'b0;
    data_rdata          = 32'd0;
    step();
    step();
    settle();
    chk("rst.req",   {31'd0, data_req},  32'd0);
    chk("rst.stall", {31'd0, stall_req}, 32'd0);
    chk("rst.done",  {31'd0, load_done}, 32'd0);
    chk("rst.addr",  data_addr,          32'd0);
    chk("rst.ldata", load_data,          32'd0);
    rst = 1'b0;
    step();

    // LB at 0x1003: top byte 0x80 sign-extends.
    fast("lb", 4'd1, 32'h0000_1003, 32'd0, 32'h80FF_FF00,
         2'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FF80);
    // SH at 0x2002: replicated halfword, no load_done, load_data untouched.
    fast("sh", 4'd7, 32'h0000_2002, 32'h0000_ABCD, 32'h1111_1111,
         2'd1, 1'b1, 32'hABCD_ABCD, 1'b0, 32'hFFFF_FF80);
    // SB replication, byte address kept unaligned.
    fast("sb", 4'd6, 32'h0000_7001, 32'h1234_56AB, 32'd0,
         2'd0, 1'b1, 32'hABAB_ABAB, 1'b0, 32'hFFFF_FF80);
    // SW passes data through unchanged.
    fast("sw", 4'd8, 32'h0000_7004, 32'hCAFE_F00D, 32'd0,
         2'd2, 1'b1, 32'hCAFE_F00D, 1'b0, 32'hFFFF_FF80);
    // LH low half, sign extension.
    fast("lh", 4'd3, 32'h0000_5000, 32'd0, 32'h1234_8001,
         2'd1, 1'b0, 32'd0, 1'b1, 32'hFFFF_8001);
    // LBU byte lane 1, zero extension.
    fast("lbu", 4'd2, 32'h0000_6001, 32'd0, 32'h0000_F200,
         2'd0, 1'b0, 32'd0, 1'b1, 32'h0000_00F2);
    // LW full word.
    fast("lw", 4'd5, 32'h0000_6004, 32'd0, 32'h89AB_CDEF,
         2'd2, 1'b0, 32'd0, 1'b1, 32'h89AB_CDEF);

    // Misaligned LW: AdEL for one cycle, no request, no stall.
    issue(4'd5, 32'h0000_3001, 32'd0);
    settle();
    chk("adel.pulse",  {31'd0, addr_err_load},  32'd1);
    chk("adel.store",  {31'd0, addr_err_store}, 32'd0);
    chk("adel.stall",  {31'd0, stall_req},      32'd0);
    step();
    drop_issue();
    settle();
    chk("adel.req",    {31'd0, data_req},       32'd0);
    chk("adel.clear",  {31'd0, addr_err_load},  32'd0);
    // Misaligned SH at odd address: AdES.
    issue(4'd7, 32'h0000_3003, 32'd0);
    settle();
    chk("ades.pulse",  {31'd0, addr_err_store}, 32'd1);
    chk("ades.load",   {31'd0, addr_err_load},  32'd0);
    // Older exception suppresses the access entirely.
    mem_exception_type = 32'h0000_0010;
    mem_op             = 4'd5;
    mem_access_mem_addr = 32'h0000_3000;
    settle();
    chk("oldexc.stall", {31'd0, stall_req}, 32'd0);
    step();
    drop_issue();
    mem_exception_type = 32'd0;
    settle();
    chk("oldexc.req",  {31'd0, data_req},       32'd0);

    // LHU at 0x4002 with addr_ok 3 cycles late, data_ok 2 cycles after.
    issue(4'd4, 32'h0000_4002, 32'd0);
    step();
    drop_issue();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lhu.wait_req",   {31'd0, data_req},  32'd1);
      chk("lhu.wait_stall", {31'd0, stall_req}, 32'd1);
      step();
    end
    data_addr_ok = 1'b1;
    settle();
    chk("lhu.ack_req", {31'd0, data_req}, 32'd1);
    step();
    data_addr_ok = 1'b0;
    settle();
    chk("lhu.wd_req",   {31'd0, data_req},  32'd0);
    chk("lhu.wd_stall", {31'd0, stall_req}, 32'd1);
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'h9234_5678;
    settle();
    chk("lhu.wd2_stall", {31'd0, stall_req}, 32'd1);
    step();
    data_data_ok = 1'b0;
    settle();
    chk("lhu.done",  {31'd0, load_done}, 32'd1);
    chk("lhu.ldata", load_data,          32'h0000_9234);
    step();

    // LW killed in WAIT_DATA; data_ok arrives 2 cycles after the flush.
    issue(4'd5, 32'h0000_8000, 32'd0);
    step();
    drop_issue();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    exception    = 1'b1;
    settle();
    chk("kill.stall_exc", {31'd0, stall_req}, 32'd1);
    step();
    exception = 1'b0;
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    step();
    data_data_ok = 1'b0;
    settle();
    chk("kill.done",  {31'd0, load_done}, 32'd0);
    chk("kill.ldata", load_data,          32'h0000_9234);
    chk("kill.stall", {31'd0, stall_req}, 32'd0);
    step();
    settle();
    chk("kill.idle_req", {31'd0, data_req}, 32'd0);
    // Back in IDLE: a new load starts normally.
    fast("postkill", 4'd5, 32'h0000_8004, 32'd0, 32'h0102_0304,
         2'd2, 1'b0, 32'd0, 1'b1, 32'h0102_0304);

    // Flush in WAIT_ADDR before addr_ok abandons the request.
    issue(4'd5, 32'h0000_9000, 32'd0);
    step();
    drop_issue();
    exception = 1'b1;
    step();
    exception = 1'b0;
    settle();
    chk("abandon.req",   {31'd0, data_req},  32'd0);
    chk("abandon.stall", {31'd0, stall_req}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h5555_5555;
    step();
    data_data_ok = 1'b0;
    settle();
    chk("abandon.done",  {31'd0, load_done}, 32'd0);
    chk("abandon.ldata", load_data,          32'h0102_0304);

    // Flush in DONE suppresses load_done.
    issue(4'd5, 32'h0000_9004, 32'd0);
    step();
    drop_issue();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h7777_7777;
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    exception    = 1'b1;
    settle();
    chk("donexc.done", {31'd0, load_done}, 32'd0);
    step();
    exception = 1'b0;

    // Reset in WAIT_DATA, then a stray data_ok.
    issue(4'd1, 32'h0000_A001, 32'd0);
    step();
    drop_issue();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    rst          = 1'b1;
    step();
    rst          = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;
    settle();
    chk("rstmid.req",   {31'd0, data_req},  32'd0);
    chk("rstmid.wr",    {31'd0, data_wr},   32'd0);
    chk("rstmid.size",  {30'd0, data_size}, 32'd0);
    chk("rstmid.addr",  data_addr,          32'd0);
    chk("rstmid.wdata", data_wdata,         32'd0);
    chk("rstmid.stall", {31'd0, stall_req}, 32'd0);
    chk("rstmid.ldata", load_data,          32'd0);
    step();
    data_data_ok = 1'b0;
    settle();
    chk("rstmid.done",   {31'd0, load_done}, 32'd0);
    chk("rstmid.req2",   {31'd0, data_req},  32'd0);
    chk("rstmid.ldata2", load_data,          32'd0);
    step();
    settle();
    chk("rstmid.done2",  {31'd0, load_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
